// File: rtl/ltc2195_frame_aligner.sv
// ---------------------------------------------------------------------------
// ltc2195_frame_aligner
//
// Bitslip alignment controller for the LTC2195 deserializer, clk_in (CLKDIV)
// domain. It issues single-cycle bitslip pulses until the deserialized frame
// word equals FRAME_PATTERN for LOCK_COUNT consecutive cycles, then reports
// lock. It reports failure once MAX_SLIPS slips have not produced a match.
//
// Optional feature macro: LTC2195_ALIGN_MONITOR_EN
//   defined   : LOCKED keeps watching FR_in. LOSS_COUNT consecutive
//               mismatches drop lock and restart alignment automatically.
//   undefined : LOCKED is terminal until align_start_in or reset.
//
// Ports
//   clk_in          in   divided deserializer clock, rising edge
//   rst_n_in        in   asynchronous active-low reset
//   align_start_in  in   one-cycle pulse: start/restart alignment
//   FR_in[7:0]      in   deserialized frame word
//   bitslip_out     out  one-cycle bitslip pulse to the ISERDES
//   busy_out        out  high in SETTLE, CHECK and SLIP
//   aligned_out     out  high in LOCKED
//   align_fail_out  out  high in FAIL
//   slip_count_out  out  slips issued since the last start
//
// All outputs are registered and valid in the same cycle as the state they
// describe (they are loaded from the next-state value).
// ---------------------------------------------------------------------------
module ltc2195_frame_aligner #(
   parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned LOCK_COUNT    = 16,
   parameter int unsigned MAX_SLIPS     = 8,
   parameter int unsigned LOSS_COUNT    = 4
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       align_start_in,
   input  logic [7:0] FR_in,
   output logic       bitslip_out,
   output logic       busy_out,
   output logic       aligned_out,
   output logic       align_fail_out,
   output logic [3:0] slip_count_out
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned MATCH_W = 8;

   localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
   localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0]   SLIP_LIMIT  = CNT_W'(MAX_SLIPS);

   // Elaboration-time parameter range checks
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must be 1..15");
   end
   if (LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : g_bad_lock
      $error("LOCK_COUNT must be 1..255");
   end
   if (MAX_SLIPS < 1 || MAX_SLIPS > 15) begin : g_bad_slips
      $error("MAX_SLIPS must be 1..15");
   end
   if (LOSS_COUNT < 1 || LOSS_COUNT > 15) begin : g_bad_loss
      $error("LOSS_COUNT must be 1..15");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      CHECK  = 3'd2,
      SLIP   = 3'd3,
      LOCKED = 3'd4,
      FAIL   = 3'd5
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     settle_cnt;
   logic [CNT_W-1:0]     settle_nxt;
   logic [MATCH_W-1:0]   match_cnt;
   logic [MATCH_W-1:0]   match_nxt;
   logic [MATCH_W-1:0]   match_inc;
   logic [CNT_W-1:0]     slip_nxt;
   logic                 bitslip_nxt;
   logic                 busy_nxt;
   logic                 aligned_nxt;
   logic                 fail_nxt;
   logic                 frame_match;

`ifdef LTC2195_ALIGN_MONITOR_EN
   localparam logic [CNT_W-1:0] LOSS_TARGET = CNT_W'(LOSS_COUNT);

   logic [CNT_W-1:0]     loss_cnt;
   logic [CNT_W-1:0]     loss_nxt;
   logic [CNT_W-1:0]     loss_inc;
`endif

   assign frame_match = (FR_in == FRAME_PATTERN);

   // State, counter and output registers
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= IDLE;
         settle_cnt     <= '0;
         match_cnt      <= '0;
         slip_count_out <= '0;
         bitslip_out    <= 1'b0;
         busy_out       <= 1'b0;
         aligned_out    <= 1'b0;
         align_fail_out <= 1'b0;
`ifdef LTC2195_ALIGN_MONITOR_EN
         loss_cnt       <= '0;
`endif
      end else begin
         state          <= state_nxt;
         settle_cnt     <= settle_nxt;
         match_cnt      <= match_nxt;
         slip_count_out <= slip_nxt;
         bitslip_out    <= bitslip_nxt;
         busy_out       <= busy_nxt;
         aligned_out    <= aligned_nxt;
         align_fail_out <= fail_nxt;
`ifdef LTC2195_ALIGN_MONITOR_EN
         loss_cnt       <= loss_nxt;
`endif
      end
   end

   // Next-state, counter and output decode
   always_comb begin
      state_nxt  = state;
      settle_nxt = '0;
      match_nxt  = match_cnt;
      slip_nxt   = slip_count_out;
      // Saturating increment: the match counter never passes LOCK_COUNT
      match_inc  = (match_cnt < LOCK_TARGET) ? match_cnt + MATCH_W'(1) : match_cnt;
`ifdef LTC2195_ALIGN_MONITOR_EN
      loss_nxt   = '0;
      loss_inc   = (loss_cnt < LOSS_TARGET) ? loss_cnt + CNT_W'(1) : loss_cnt;
`endif

      case (state)
         IDLE: begin
            state_nxt = IDLE;
         end

         // Entry cycle plus SETTLE_CYCLES counted cycles; FR_in is ignored
         SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_nxt = CHECK;
            end else begin
               settle_nxt = settle_cnt + CNT_W'(1);
            end
         end

         CHECK: begin
            if (frame_match) begin
               match_nxt = match_inc;
               if (match_inc == LOCK_TARGET) begin
                  state_nxt = LOCKED;
               end
            end else begin
               match_nxt = '0;
               if (slip_count_out < SLIP_LIMIT) begin
                  state_nxt = SLIP;
                  slip_nxt  = slip_count_out + CNT_W'(1);
               end else begin
                  state_nxt = FAIL;
               end
            end
         end

         SLIP: begin
            state_nxt = SETTLE;
         end

         LOCKED: begin
`ifdef LTC2195_ALIGN_MONITOR_EN
            // Consecutive-mismatch supervision; one good frame clears it
            if (!frame_match) begin
               if (loss_inc == LOSS_TARGET) begin
                  state_nxt = SETTLE;
                  match_nxt = '0;
                  slip_nxt  = '0;
               end else begin
                  loss_nxt = loss_inc;
               end
            end
`else
            state_nxt = LOCKED;
`endif
         end

         FAIL: begin
            state_nxt = FAIL;
         end

         default: begin
            state_nxt = IDLE;
            match_nxt = '0;
            slip_nxt  = '0;
         end
      endcase

      // Start overrides every other transition, including an active SLIP
      if (align_start_in) begin
         state_nxt  = SETTLE;
         settle_nxt = '0;
         match_nxt  = '0;
         slip_nxt   = '0;
`ifdef LTC2195_ALIGN_MONITOR_EN
         loss_nxt   = '0;
`endif
      end

      bitslip_nxt = (state_nxt == SLIP);
      busy_nxt    = (state_nxt == SETTLE) || (state_nxt == CHECK) || (state_nxt == SLIP);
      aligned_nxt = (state_nxt == LOCKED);
      fail_nxt    = (state_nxt == FAIL);
   end

endmodule

// File: tb/tb_ltc2195_frame_aligner.sv
// ---------------------------------------------------------------------------
// tb_ltc2195_frame_aligner
//
// Scoreboard bench. The stimulus side predicts, from the frame-rotation rule
// (each bitslip rotates the frame word left by one), how many slips a run
// needs and whether it locks or fails, and queues the expected output events.
// A monitor turns DUT output edges into events and checks them in order.
// ---------------------------------------------------------------------------
module tb_ltc2195_frame_aligner;

   localparam int unsigned S   = 4;
   localparam int unsigned L   = 16;
   localparam int unsigned M   = 8;
   localparam int unsigned LC  = 4;
   localparam logic [7:0]  PAT = 8'hF0;

   localparam int EV_SLIP   = 0;
   localparam int EV_LOCK   = 1;
   localparam int EV_FAIL   = 2;
   localparam int EV_UNLOCK = 3;

   typedef struct {
      int kind;
      int sc;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] fr_in;
   logic       bitslip;
   logic       busy;
   logic       aligned;
   logic       fail;
   logic [3:0] slip_count;

   ev_t        exp_q[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   bit         done = 1'b0;

   logic [7:0] fr_q = 8'h00;
   logic [7:0] base = 8'h00;
   int         base_id = 0;
   int         seen_id = 0;
   logic       corrupt = 1'b0;

   ltc2195_frame_aligner #(
      .FRAME_PATTERN (PAT),
      .SETTLE_CYCLES (S),
      .LOCK_COUNT    (L),
      .MAX_SLIPS     (M),
      .LOSS_COUNT    (LC)
   ) dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .align_start_in (start),
      .FR_in          (fr_in),
      .bitslip_out    (bitslip),
      .busy_out       (busy),
      .aligned_out    (aligned),
      .align_fail_out (fail),
      .slip_count_out (slip_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Deserializer model: a bitslip rotates the captured frame left by one
   always @(posedge clk) begin
      if (base_id != seen_id) begin
         fr_q    <= base;
         seen_id <= base_id;
      end else if (bitslip) begin
         fr_q <= {fr_q[6:0], fr_q[7]};
      end
   end

   assign fr_in = corrupt ? 8'h00 : fr_q;

   function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
      logic [7:0] r;
      r = x;
      for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // Slips needed to reach the pattern, or -1 if MAX slips cannot reach it
   function automatic int slips_needed(input logic [7:0] v);
      for (int k = 0; k <= int'(M); k++) begin
         if (rotl(v, k) == PAT) return k;
      end
      return -1;
   endfunction

   function automatic int out_word();
      return int'({bitslip, busy, aligned, fail, slip_count});
   endfunction

   task automatic push_ev(input int kind, input int sc, input int c);
      ev_t e;
      e.kind = kind;
      e.sc   = sc;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic push_run(input logic [7:0] v, input int st);
      int k;
      k = slips_needed(v);
      if (k >= 0) begin
         for (int i = 1; i <= k; i++) push_ev(EV_SLIP, i, -1);
         push_ev(EV_LOCK, k, (k == 0) ? st + int'(S + L) + 1 : -1);
      end else begin
         for (int i = 1; i <= int'(M); i++) push_ev(EV_SLIP, i, -1);
         push_ev(EV_FAIL, int'(M), -1);
      end
   endtask

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic on_event(input int kind);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL event: got kind %0d slips %0d cycle %0d, expected none", kind, slip_count, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.sc != int'(slip_count) || (e.cyc >= 0 && e.cyc != cyc)) begin
            fails++;
            $display("FAIL event: got kind %0d slips %0d cycle %0d, expected kind %0d slips %0d cycle %0d",
                     kind, slip_count, cyc, e.kind, e.sc, e.cyc);
         end
      end
   endtask

   task automatic monitor();
      logic p_slip;
      logic p_al;
      logic p_fail;
      int   last_slip;
      p_slip    = 1'b0;
      p_al      = 1'b0;
      p_fail    = 1'b0;
      last_slip = -1000;
      while (!done) begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (bitslip && !p_slip) begin
               on_event(EV_SLIP);
               check("slip_spacing_ok", (cyc - last_slip >= int'(S) + 2) ? 1 : 0, 1);
               last_slip = cyc;
            end
            if (aligned && !p_al) on_event(EV_LOCK);
            if (!aligned && p_al) on_event(EV_UNLOCK);
            if (fail && !p_fail)  on_event(EV_FAIL);
         end
         p_slip = bitslip;
         p_al   = aligned;
         p_fail = fail;
      end
   endtask

   // Issue a start pulse; load a new frame base first when requested
   task automatic go(input string name, input bit load, input logic [7:0] b);
      logic [7:0] v;
      v = load ? b : fr_q;
      if (load) begin
         base = b;
         base_id++;
      end
      start = 1'b1;
      if (aligned) push_ev(EV_UNLOCK, 0, cyc + 1);
      push_run(v, cyc + 1);
      tick();
      start = 1'b0;
      check({name, "_restart_outputs"}, out_word(), 64);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      tick();
      while (busy && n < 2000) begin
         tick();
         n++;
      end
      check({name, "_finished_ok"}, (n < 2000) ? 1 : 0, 1);
      @(negedge clk);
      #1;
      check({name, "_events_pending"}, exp_q.size(), 0);
   endtask

   task automatic stimulus();
      int         n;
      int         k;
      int         c0;
      logic [7:0] b;

      rst_n   = 1'b0;
      start   = 1'b0;
      base    = PAT;
      base_id = 1;
      repeat (3) tick();
      check("reset_outputs", out_word(), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_outputs", out_word(), 0);
      end

      // Already aligned: lock with no slips, exact latency via scoreboard
      go("lock_direct", 1'b1, PAT);
      wait_done("lock_direct");
      check("lock_direct_aligned", int'(aligned), 1);
      check("lock_direct_slips", int'(slip_count), 0);

      // Three slips from 8'h1E
      go("lock_slip3", 1'b1, 8'h1E);
      wait_done("lock_slip3");
      check("lock_slip3_aligned", int'(aligned), 1);
      check("lock_slip3_slips", int'(slip_count), 3);

      // Never matching: MAX slips then FAIL; restart clears fail at once
      go("fail_aa", 1'b1, 8'hAA);
      wait_done("fail_aa");
      check("fail_aa_flag", int'(fail), 1);
      check("fail_aa_slips", int'(slip_count), int'(M));
      check("fail_aa_aligned", int'(aligned), 0);
      go("fail_restart", 1'b0, 8'h00);
      wait_done("fail_restart");
      check("fail_restart_flag", int'(fail), 1);

      // Random frame bases: half are pattern rotations, half arbitrary bytes
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 1) == 1) b = rotl(PAT, int'($urandom_range(0, 7)));
         else                           b = 8'($urandom);
         k = slips_needed(b);
         go("rand", 1'b1, b);
         wait_done("rand");
         if (k >= 0) begin
            check("rand_aligned", int'(aligned), 1);
            check("rand_slips", int'(slip_count), k);
         end else begin
            check("rand_fail", int'(fail), 1);
            check("rand_fail_slips", int'(slip_count), int'(M));
         end
      end

      // Lock supervision: short glitch never drops lock
      go("mon_base", 1'b1, PAT);
      wait_done("mon_base");
      corrupt = 1'b1;
      repeat (LC - 1) begin
         tick();
         check("glitch_short_aligned", int'(aligned), 1);
      end
      corrupt = 1'b0;
      repeat (4) begin
         tick();
         check("glitch_short_after", int'(aligned), 1);
      end

      // Longer glitch: realign with the monitor, ignored without it
      c0 = cyc;
`ifdef LTC2195_ALIGN_MONITOR_EN
      push_ev(EV_UNLOCK, 0, c0 + int'(LC));
      push_ev(EV_LOCK, 0, c0 + int'(LC) + int'(S + L) + 1);
`endif
      corrupt = 1'b1;
      repeat (LC) tick();
      corrupt = 1'b0;
`ifdef LTC2195_ALIGN_MONITOR_EN
      check("glitch_long_dropped", int'(aligned), 0);
      wait_done("glitch_long");
      check("glitch_long_relocked", int'(aligned), 1);
      check("glitch_long_slips", int'(slip_count), 0);
`else
      check("glitch_long_held", int'(aligned), 1);
      repeat (S + L + 4) begin
         tick();
         check("glitch_long_still_locked", out_word(), 32);
      end
      check("glitch_long_events_pending", exp_q.size(), 0);
`endif

      // Start pulse while SLIP is active
      base = 8'h1E;
      base_id++;
      start = 1'b1;
      if (aligned) push_ev(EV_UNLOCK, 0, cyc + 1);
      push_ev(EV_SLIP, 1, -1);
      tick();
      start = 1'b0;
      n = 0;
      while (!bitslip && n < 200) begin
         tick();
         n++;
      end
      check("slip_seen", int'(bitslip), 1);
      if (bitslip) begin
         start = 1'b1;
         push_run(rotl(fr_q, 1), cyc + 1);
         tick();
         start = 1'b0;
         check("slip_restart_outputs", out_word(), 64);
         wait_done("slip_restart");
         check("slip_restart_aligned", int'(aligned), 1);
         check("slip_restart_slips", int'(slip_count), 2);
      end

      // Reset pulse in the middle of SETTLE
      go("rst_run", 1'b1, PAT);
      tick();
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", out_word(), 0);
      exp_q.delete();
      tick();
      tick();
      check("reset_hold_outputs", out_word(), 0);
      rst_n = 1'b1;
      tick();
      check("post_reset_idle", out_word(), 0);
      go("after_reset", 1'b0, 8'h00);
      wait_done("after_reset");
      check("after_reset_aligned", int'(aligned), 1);
      check("after_reset_slips", int'(slip_count), 0);
   endtask

   initial begin
      fork
         begin
            stimulus();
            done = 1'b1;
         end
         monitor();
      join
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
